// File: rtl/srcnt_deser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// srcnt_deser : gathers synchronised srcnt bit strobes into WIDTH-bit words,
//               flags words with unknown bits, queues them for a ready/valid host.
// Revision    : 1.0
// ============================================================================
module srcnt_deser #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 2,
  parameter int MSB_FIRST = 0,
  parameter int TIMEOUT   = 16
) (
  input  logic                       clkin,
  input  logic                       rst,
  input  logic                       bit_valid,
  input  logic                       bit_data,
  input  logic                       flush,
  input  logic                       ovf_clr,
  output logic [WIDTH-1:0]           word_out,
  output logic                       word_err,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [$clog2(WIDTH):0]     bit_cnt,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic                       frag_err
);

  localparam int c_cnt_w  = $clog2(WIDTH) + 1;
  localparam int c_idx_w  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int c_ptr_w  = $clog2(DEPTH);
  localparam int c_lvl_w  = $clog2(DEPTH) + 1;
  localparam int c_idle_w = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     sr_q, sr_d;
  logic                 err_q, err_d;
  logic [c_cnt_w-1:0]   bit_cnt_q, bit_cnt_d;
  logic [c_idle_w-1:0]  idle_q, idle_d;
  logic                 frag_q, frag_d;

  logic                 w_push_req;
  logic [WIDTH-1:0]     w_push_word;
  logic                 w_push_err;
  logic                 w_bit_x;
  logic                 w_bit_val;
  logic                 w_err_acc;
  logic [c_idx_w-1:0]   w_pos;

  // Anything other than a clean 0/1 (X or Z) marks the word as corrupt.
  assign w_bit_x   = (bit_data !== 1'b0) && (bit_data !== 1'b1);
  assign w_bit_val = (bit_data === 1'b1);

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_pos = c_idx_w'(WIDTH - 1) - bit_cnt_q[c_idx_w-1:0];
    end else begin : g_lsb_first
      assign w_pos = bit_cnt_q[c_idx_w-1:0];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    err_d       = err_q;
    bit_cnt_d   = bit_cnt_q;
    idle_d      = '0;
    frag_d      = 1'b0;
    w_push_req  = 1'b0;
    w_push_word = '0;
    w_push_err  = 1'b0;
    w_err_acc   = 1'b0;

    if (flush) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      err_d     = 1'b0;
    end else if (bit_valid) begin
      if (state_q == S_IDLE) begin
        sr_d      = '0;
        w_err_acc = w_bit_x;
      end else begin
        w_err_acc = err_q | w_bit_x;
      end
      sr_d[w_pos] = w_bit_val;
      if (bit_cnt_q == c_cnt_w'(WIDTH - 1)) begin
        w_push_req  = 1'b1;
        w_push_word = sr_d;
        w_push_err  = w_err_acc;
        err_d       = 1'b0;
        bit_cnt_d   = '0;
        state_d     = S_IDLE;
      end else begin
        err_d     = w_err_acc;
        bit_cnt_d = bit_cnt_q + 1'b1;
        state_d   = S_COLLECT;
      end
    end else if (state_q == S_COLLECT) begin
      if (idle_q == c_idle_w'(TIMEOUT - 1)) begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
        err_d     = 1'b0;
        frag_d    = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sr_q      <= '0;
      err_q     <= 1'b0;
      bit_cnt_q <= '0;
      idle_q    <= '0;
      frag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      err_q     <= err_d;
      bit_cnt_q <= bit_cnt_d;
      idle_q    <= idle_d;
      frag_q    <= frag_d;
    end
  end

  // Output FIFO: first-word fall-through, pointers wrap on their natural width.
  logic [WIDTH-1:0]   mem_word [DEPTH];
  logic [DEPTH-1:0]   mem_err;
  logic [c_ptr_w-1:0] wr_ptr_q, rd_ptr_q;
  logic [c_lvl_w-1:0] level_q;
  logic               ovf_q;

  logic w_full;
  logic w_nonempty;
  logic w_pop;
  logic w_push;

  assign w_nonempty = (level_q != '0);
  assign w_full     = (level_q == c_lvl_w'(DEPTH));
  assign w_pop      = w_nonempty & word_ready;
  assign w_push     = w_push_req & (~w_full | w_pop);

  always_ff @(posedge clkin) begin
    if (w_push) begin
      mem_word[wr_ptr_q] <= w_push_word;
      mem_err[wr_ptr_q]  <= w_push_err;
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (w_push_req & w_full & ~w_pop) ovf_q <= 1'b1;
      else if (ovf_clr)                 ovf_q <= 1'b0;
    end
  end

  assign word_valid = w_nonempty;
  assign word_out   = w_nonempty ? mem_word[rd_ptr_q] : '0;
  assign word_err   = w_nonempty & mem_err[rd_ptr_q];
  assign bit_cnt    = bit_cnt_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign frag_err   = frag_q;

endmodule
`default_nettype wire

// File: doc/srcnt_deser.md
Name: srcnt_deser

Overview:
- Serial-to-parallel collector that sits directly downstream of the last srcnt stage in a counterflow shift-register chain.
- Consumes the per-bit data/clock pulse pair after synchronisation into the system clock domain, one strobe per bit.
- Assembles bits into WIDTH-bit words, flags words containing a hold/setup-violated (X) bit, and buffers words in a small FIFO.
- Presents words to the host with a valid/ready handshake.

Parameters:
- WIDTH, 8, bits per assembled word.
- DEPTH, 2, output FIFO entries; power of two, at least 2.
- MSB_FIRST, 0, 0 = first received bit lands in word_out[0]; 1 = first received bit lands in word_out[WIDTH-1].
- TIMEOUT, 16, idle clkin cycles allowed between bits of a partial word before it is discarded.

Ports:
- clkin  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- bit_valid  input  1  one-cycle strobe: one bit available (synchronised srcnt clkout).
- bit_data  input  1  bit value, sampled when bit_valid=1 (synchronised srcnt dout; may be 1'bx).
- flush  input  1  discard any partial word.
- ovf_clr  input  1  clear sticky overflow.
- word_out  output  WIDTH  FIFO head word.
- word_err  output  1  head word contains at least one X bit.
- word_valid  output  1  FIFO non-empty.
- word_ready  input  1  host accepts the head word when word_valid & word_ready.
- bit_cnt  output  $clog2(WIDTH)+1  bits collected in the current partial word.
- fifo_level  output  $clog2(DEPTH)+1  occupied FIFO entries.
- overflow  output  1  sticky: a completed word was dropped because the FIFO was full.
- frag_err  output  1  one-cycle pulse: a partial word was discarded by timeout.

Behaviour:
- Reset (asynchronous, any time, including mid-word or mid-handshake):
  - word_out=0, word_err=0, word_valid=0, bit_cnt=0, fifo_level=0, overflow=0, frag_err=0.
  - Shift register, error accumulator, idle counter and FIFO pointers all cleared.
- Collector FSM, two states:
  - IDLE (bit_cnt=0): bit_valid=1 loads the first bit, bit_cnt becomes 1, moves to COLLECT. If WIDTH=1, the word completes immediately instead.
  - COLLECT: each bit_valid shifts in one bit and bit_cnt increments.
  - When the bit raising bit_cnt to WIDTH arrives, the completed word and its err flag are pushed on that same edge, bit_cnt returns to 0, and the FSM returns to IDLE.
- Bit ordering follows MSB_FIRST as defined under Parameters.
- X handling:
  - bit_data===1'bx sets the word's err accumulator and stores 0 in that bit position.
  - Accumulator clears on push, flush, timeout or reset.
  - Z is treated as X.
- Timeout:
  - In COLLECT, the idle counter increments on every cycle without bit_valid and resets to 0 on each bit.
  - When the counter reaches TIMEOUT, the partial word is discarded, bit_cnt=0, the FSM returns to IDLE, and frag_err pulses for exactly one cycle.
  - The counter is inactive in IDLE.
- Flush:
  - The partial word is discarded and the FSM goes to IDLE; no frag_err.
  - flush wins over a coincident bit_valid: that bit is dropped.
  - flush does not touch FIFO contents.
- FIFO:
  - Latency: a word pushed on edge N is visible on word_out/word_err with word_valid=1 after edge N (first-word fall-through).
  - Pop occurs on any edge where word_valid & word_ready.
  - Push and pop on the same edge: both happen; fifo_level is unchanged. This also holds when full, since the pop frees the slot.
  - Push when full without a pop: the word is dropped, overflow becomes 1, and FIFO contents are unchanged.
  - word_ready while empty is ignored; no underflow and fifo_level stays 0.
  - Pointers wrap modulo DEPTH.
  - word_out and word_err hold the head entry and are stable while word_valid=1 and word_ready=0.
- overflow:
  - Cleared by ovf_clr.
  - If ovf_clr coincides with a new overflow event, overflow stays 1 (set wins).
- bit_cnt and fifo_level are registered and reflect post-edge state.

Test Plan:
- Reset, WIDTH=8, MSB_FIRST=0, bit_data sequence 1,0,1,1,0,0,0,0 with word_ready=1 -> word_valid rises one cycle after the 8th strobe, word_out=8'h0D, word_err=0, fifo_level back to 0 after the pop.
- Same bit sequence with MSB_FIRST=1 -> word_out=8'hB0.
- Eight bits with the 3rd bit = 1'bx, all other bits 1 -> word_out=8'hFB, word_err=1. The next clean word has word_err=0.
- word_ready=0, push three words 8'h11, 8'h22, 8'h33 -> fifo_level=2, overflow=1, head=8'h11. Then ready=1 -> 8'h11 followed by 8'h22, 8'h33 never appears. Pulse ovf_clr -> overflow=0.
- FIFO full with word_ready=1 on the same edge that the next word completes -> fifo_level stays 2 and no overflow.
- Five bits, then 16 idle cycles -> frag_err pulses once and bit_cnt=0. Next 8 bits form a clean word. Also assert rst mid-word (bit_cnt=4) with 1 word queued -> all outputs 0 immediately, without waiting for a clkin edge.
